l1_dcache_wt: RTL

Direct-mapped, write-through, no-write-allocate L1 data cache. It is the cache-side responder on the CPU data-cache interface: it answers load and store requests from the core's MEM stage and forwards misses and all stores to the memory-side master port. It blocks, so at most one core transaction is in flight.

---
 rtl/l1_dcache_wt.sv | 127 ++++++++++++
 1 files changed

// File: rtl/l1_dcache_wt.sv
// l1_dcache_wt: blocking direct-mapped write-through, no-write-allocate L1 data cache
module l1_dcache_wt #(
    parameter int INDEX_BITS = 6,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_in,
    input  logic [2:0]  core_type,
    output logic [31:0] core_out,
    output logic        core_wait,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_type,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic        mem_wait
);
    localparam int WB = $clog2(LINE_WORDS);
    localparam int OB = WB + 2;
    localparam int TB = 32 - INDEX_BITS - OB;
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
    state_t state, state_nx;

    logic [WB-1:0]         cnt;
    logic [LINES-1:0]      valid;
    logic [TB-1:0]         tags [LINES];
    logic [31:0]           data [LINES][LINE_WORDS];
    logic [31:2]           req_addr;
    logic [INDEX_BITS-1:0] idx, ridx;
    logic [TB-1:0]         tag, rtag;
    logic [WB-1:0]         word, rword;
    logic                  hit, last;
    logic [3:0]            mask;
    logic [31:0]           merged;

    assign idx   = core_addr[OB+INDEX_BITS-1:OB];
    assign tag   = core_addr[31:OB+INDEX_BITS];
    assign word  = core_addr[OB-1:2];
    assign ridx  = req_addr[OB+INDEX_BITS-1:OB];
    assign rtag  = req_addr[31:OB+INDEX_BITS];
    assign rword = req_addr[OB-1:2];
    assign hit   = valid[idx] && tags[idx] == tag;
    assign last  = cnt == WB'(LINE_WORDS - 1);
    assign mask  = core_type[1] ? 4'hf : core_type[0] ? (core_addr[1] ? 4'hc : 4'h3) : 4'b0001 << core_addr[1:0];

    // store data merged into the cached word under the byte-lane mask
    always_comb begin
        merged = data[idx][word];
        for (int i = 0; i < 4; i++)
            if (mask[i]) merged[8*i +: 8] = core_in[8*i +: 8];
    end

    // next state and all combinational core/memory outputs
    always_comb begin
        state_nx  = state;
        core_wait = 1'b0;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_addr  = 32'h0;
        mem_type  = 3'b000;
        mem_in    = 32'h0;
        case (state)
            IDLE: begin
                core_wait = core_req && (core_write || !hit);
                if (core_req) state_nx = core_write ? WRITE : hit ? IDLE : REFILL;
            end
            REFILL: begin
                core_wait = 1'b1;
                mem_req   = 1'b1;
                mem_addr  = {req_addr[31:OB], cnt, 2'b00};
                mem_type  = 3'b010;
                if (!mem_wait && last) state_nx = DONE;
            end
            WRITE: begin
                core_wait = 1'b1;
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_addr  = core_addr;
                mem_type  = core_type;
                mem_in    = core_in;
                if (!mem_wait) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // control state, valid bits and the registered load result
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            valid    <= '0;
            core_out <= 32'h0;
            req_addr <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && core_req) begin
                req_addr <= core_addr[31:2];
                cnt      <= '0;
            end
            if (state == IDLE && core_req && !core_write && hit) core_out <= data[idx][word];
            if (state == REFILL && !mem_wait) begin
                cnt <= cnt + WB'(1);
                if (last) begin
                    valid[ridx] <= 1'b1;
                    core_out    <= rword == cnt ? mem_out : data[ridx][rword];
                end
            end
        end
    end

    // tag and data storage: refill words and store-hit merges, no reset needed
    always_ff @(posedge clk) begin
        if (state == IDLE && core_req && core_write && hit) data[idx][word] <= merged;
        if (state == REFILL && !mem_wait) begin
            data[ridx][cnt] <= mem_out;
            if (last) tags[ridx] <= rtag;
        end
    end
endmodule
